// File: rtl/mini16sc_boot_ctrl.sv
// Boot/supervise sequencer for one mini16sc core: streams a program into IMEM
// under soft reset, runs the core, and halts it on a mailbox store or cycle budget.
module mini16sc_boot_ctrl #(
  parameter int                 WIDTH_I   = 16,
  parameter int                 DEPTH_I   = 8,
  parameter int                 WIDTH_D   = 16,
  parameter int                 DEPTH_D   = 8,
  parameter logic [DEPTH_D-1:0] DONE_ADDR = 8'hff,
  parameter int                 CNT_BITS  = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_start,
  input  logic [DEPTH_I:0]    cmd_len,
  input  logic [CNT_BITS-1:0] cmd_timeout,
  input  logic                prog_valid,
  input  logic [WIDTH_I-1:0]  prog_data,
  output logic                prog_ready,
  output logic [DEPTH_I-1:0]  imem_w_addr,
  output logic [WIDTH_I-1:0]  imem_w_data,
  output logic                imem_we,
  output logic                cpu_soft_reset,
  input  logic                snoop_d_we,
  input  logic [DEPTH_D-1:0]  snoop_d_w_addr,
  input  logic [WIDTH_D-1:0]  snoop_d_w_data,
  output logic                busy,
  output logic                done,
  output logic                timed_out,
  output logic [WIDTH_D-1:0]  result,
  output logic [CNT_BITS-1:0] cycles
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RELEASE, S_RUN, S_HALT} state_t;

  localparam logic [DEPTH_I:0] LEN_MAX = {1'b1, {DEPTH_I{1'b0}}};

  state_t              r_state, w_next;
  logic [DEPTH_I:0]    r_len;
  logic [DEPTH_I-1:0]  r_cnt;
  logic [CNT_BITS-1:0] r_timeout, r_cycles;
  logic [WIDTH_D-1:0]  r_result;
  logic                r_done, r_to, r_we;
  logic [DEPTH_I-1:0]  r_waddr;
  logic [WIDTH_I-1:0]  r_wdata;

  logic                w_idle_like, w_start, w_accept, w_last;
  logic                w_done_hit, w_timeout;
  logic [DEPTH_I:0]    w_len_clip;
  logic [CNT_BITS-1:0] w_cyc_p1;

  assign w_idle_like = (r_state == S_IDLE) || (r_state == S_HALT);
  assign w_start     = cmd_start && w_idle_like;
  assign w_accept    = prog_valid && prog_ready;
  assign w_last      = (({1'b0, r_cnt}) + {{DEPTH_I{1'b0}}, 1'b1}) == r_len;
  assign w_len_clip  = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;
  assign w_cyc_p1    = r_cycles + {{(CNT_BITS-1){1'b0}}, 1'b1};
  assign w_done_hit  = snoop_d_we && (snoop_d_w_addr == DONE_ADDR);
  // Compare against the unsaturated increment so a saturated counter never re-fires.
  assign w_timeout   = (r_timeout != '0) && (w_cyc_p1 == r_timeout);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_HALT: if (cmd_start) w_next = (cmd_len != '0) ? S_LOAD : S_RELEASE;
      S_LOAD:         if (w_accept && w_last) w_next = S_RELEASE;
      S_RELEASE:      w_next = S_RUN;
      S_RUN:          if (w_done_hit || w_timeout) w_next = S_HALT;
      default:        w_next = S_IDLE;
    endcase
  end

  always_comb begin
    prog_ready     = (r_state == S_LOAD);
    cpu_soft_reset = (r_state != S_RUN);
    busy           = (r_state == S_LOAD) || (r_state == S_RELEASE) || (r_state == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_len     <= '0;
      r_cnt     <= '0;
      r_timeout <= '0;
      r_cycles  <= '0;
      r_result  <= '0;
      r_done    <= 1'b0;
      r_to      <= 1'b0;
      r_we      <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
    end else begin
      r_we <= w_accept;
      if (w_accept) begin
        r_waddr <= r_cnt;
        r_wdata <= prog_data;
        r_cnt   <= r_cnt + {{(DEPTH_I-1){1'b0}}, 1'b1};
      end
      if (w_start) begin
        r_len     <= w_len_clip;
        r_timeout <= cmd_timeout;
        r_done    <= 1'b0;
        r_to      <= 1'b0;
        r_result  <= '0;
        r_cycles  <= '0;
        r_cnt     <= '0;
      end
      if (r_state == S_RUN) begin
        r_cycles <= (&r_cycles) ? r_cycles : w_cyc_p1;
        if (w_done_hit) begin
          r_done   <= 1'b1;
          r_result <= snoop_d_w_data;
        end else if (w_timeout) begin
          r_to <= 1'b1;
        end
      end
    end
  end

  assign imem_we     = r_we;
  assign imem_w_addr = r_waddr;
  assign imem_w_data = r_wdata;
  assign done        = r_done;
  assign timed_out   = r_to;
  assign result      = r_result;
  assign cycles      = r_cycles;

endmodule

// File: tb/tb_mini16sc_boot_ctrl.sv
// Scoreboard bench for mini16sc_boot_ctrl: IMEM writes and end-of-run status
// are checked by monitors against expectations queued by the stimulus.
module tb_mini16sc_boot_ctrl;

  logic        clk, reset, cmd_start, prog_valid, prog_ready;
  logic [8:0]  cmd_len;
  logic [23:0] cmd_timeout, cycles;
  logic [15:0] prog_data, imem_w_data, snoop_d_w_data, result;
  logic [7:0]  imem_w_addr, snoop_d_w_addr;
  logic        imem_we, cpu_soft_reset, snoop_d_we, busy, done, timed_out;

  mini16sc_boot_ctrl dut (
    .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_len(cmd_len),
    .cmd_timeout(cmd_timeout), .prog_valid(prog_valid), .prog_data(prog_data),
    .prog_ready(prog_ready), .imem_w_addr(imem_w_addr), .imem_w_data(imem_w_data),
    .imem_we(imem_we), .cpu_soft_reset(cpu_soft_reset), .snoop_d_we(snoop_d_we),
    .snoop_d_w_addr(snoop_d_w_addr), .snoop_d_w_data(snoop_d_w_data), .busy(busy),
    .done(done), .timed_out(timed_out), .result(result), .cycles(cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [7:0] addr; logic [15:0] data; } wr_t;
  typedef struct { logic d; logic t; logic [15:0] r; logic [23:0] c; } res_t;

  wr_t  exp_wr[$];
  res_t exp_res[$];
  int   n_chk = 0, n_pass = 0;
  bit   ign_fall = 1'b0;
  logic prev_busy = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // IMEM write monitor
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (exp_wr.size() == 0) begin
        n_chk++;
        $display("FAIL imem_unexpected: got write %0h<=%0h expected none", imem_w_addr, imem_w_data);
      end else begin
        wr_t w;
        w = exp_wr.pop_front();
        chk("imem_addr", {56'd0, imem_w_addr}, {56'd0, w.addr});
        chk("imem_data", {48'd0, imem_w_data}, {48'd0, w.data});
      end
    end
  end

  // End-of-run monitor: busy falling marks entry to HALT
  always @(negedge clk) begin
    if (prev_busy && busy === 1'b0 && !ign_fall) begin
      if (exp_res.size() == 0) begin
        n_chk++;
        $display("FAIL run_unexpected: got run end expected none");
      end else begin
        res_t r;
        r = exp_res.pop_front();
        chk("done",      {63'd0, done},       {63'd0, r.d});
        chk("timed_out", {63'd0, timed_out},  {63'd0, r.t});
        chk("result",    {48'd0, result},     {48'd0, r.r});
        chk("cycles",    {40'd0, cycles},     {40'd0, r.c});
        chk("halt_srst", {63'd0, cpu_soft_reset}, 64'd1);
      end
    end
    prev_busy = (busy === 1'b1);
  end

  task automatic start(input logic [8:0] len, input logic [23:0] to);
    cmd_start = 1'b1; cmd_len = len; cmd_timeout = to;
    @(posedge clk); #1;
    cmd_start = 1'b0;
  endtask

  task automatic load(input logic [15:0] w [4], input bit gappy, output int rdy, output int bsy_lo);
    int k, cyc;
    k = 0; cyc = 0; rdy = 0; bsy_lo = 0;
    while (k < 4 && cyc < 64) begin
      prog_valid = gappy ? cyc[0] : 1'b1;
      prog_data  = w[k];
      @(negedge clk);
      if (prog_ready) rdy++;
      if (!busy) bsy_lo++;
      if (prog_valid && prog_ready) begin
        exp_wr.push_back('{addr: 8'(k), data: w[k]});
        k++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    prog_valid = 1'b0;
    if (k < 4) chk("load_timeout", 64'(k), 64'd4);
  endtask

  // In RELEASE on entry; leaves at the start of RUN cycle 1
  task automatic release_chk();
    @(negedge clk);
    chk("rel_ready", {63'd0, prog_ready}, 64'd0);
    chk("rel_srst",  {63'd0, cpu_soft_reset}, 64'd1);
    chk("rel_busy",  {63'd0, busy}, 64'd1);
    @(posedge clk); #1;
    chk("run_srst",  {63'd0, cpu_soft_reset}, 64'd0);
  endtask

  task automatic run_phase(input int oth_c, input int mb_c, input logic [15:0] mb_d,
                           input int maxc, input bit poke, output int end_c);
    end_c = maxc + 1;
    for (int c = 1; c <= maxc; c++) begin
      snoop_d_we     = (c == oth_c) || (c == mb_c);
      snoop_d_w_addr = (c == mb_c) ? 8'hff : 8'h10;
      snoop_d_w_data = (c == mb_c) ? mb_d : 16'hbeef;
      cmd_start      = poke && (c == 5);
      cmd_len        = 9'd4;
      @(posedge clk); #1;
      snoop_d_we = 1'b0; cmd_start = 1'b0;
      if (poke && c == 5) begin
        chk("poke_srst",  {63'd0, cpu_soft_reset}, 64'd0);
        chk("poke_ready", {63'd0, prog_ready}, 64'd0);
      end
      if (!busy) begin end_c = c; break; end
    end
  endtask

  logic [15:0] wa [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
  logic [15:0] wb [4] = '{16'h7001, 16'h7002, 16'h7003, 16'h7004};
  int rdy, blo, endc;

  initial begin
    reset = 1'b1; cmd_start = 1'b0; cmd_len = '0; cmd_timeout = '0;
    prog_valid = 1'b0; prog_data = '0;
    snoop_d_we = 1'b0; snoop_d_w_addr = '0; snoop_d_w_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {63'd0, prog_ready}, 64'd0);
    chk("rst_we",    {63'd0, imem_we}, 64'd0);
    chk("rst_addr",  {56'd0, imem_w_addr}, 64'd0);
    chk("rst_data",  {48'd0, imem_w_data}, 64'd0);
    chk("rst_srst",  {63'd0, cpu_soft_reset}, 64'd1);
    chk("rst_busy",  {63'd0, busy}, 64'd0);
    chk("rst_done",  {63'd0, done}, 64'd0);
    chk("rst_to",    {63'd0, timed_out}, 64'd0);
    chk("rst_res",   {48'd0, result}, 64'd0);
    chk("rst_cyc",   {40'd0, cycles}, 64'd0);
    @(posedge clk); #1; reset = 1'b0;

    // continuous load, run ending on mailbox at RUN cycle 10
    start(9'd4, 24'd0);
    load(wa, 1'b0, rdy, blo);
    chk("ready_cycles", 64'(rdy), 64'd4);
    chk("busy_in_load", 64'(blo), 64'd0);
    release_chk();
    exp_res.push_back('{d: 1'b1, t: 1'b0, r: 16'h1234, c: 24'd10});
    run_phase(3, 10, 16'h1234, 40, 1'b0, endc);
    chk("mb_end_cycle", 64'(endc), 64'd10);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("halt_hold_done", {63'd0, done}, 64'd1);
    chk("halt_hold_res",  {48'd0, result}, 64'h1234);
    @(posedge clk); #1;

    // gappy load, then timeout of 100 with no mailbox
    start(9'd4, 24'd100);
    load(wa, 1'b1, rdy, blo);
    chk("gap_ready_cycles", 64'(rdy), 64'd8);
    release_chk();
    exp_res.push_back('{d: 1'b0, t: 1'b1, r: 16'h0000, c: 24'd100});
    run_phase(0, 0, 16'h0, 120, 1'b0, endc);
    chk("to_end_cycle", 64'(endc), 64'd100);
    @(posedge clk); #1;

    // skip load; mailbox and timeout coincide; start during RUN is ignored
    start(9'd0, 24'd100);
    release_chk();
    exp_res.push_back('{d: 1'b1, t: 1'b0, r: 16'hc0de, c: 24'd100});
    run_phase(0, 100, 16'hc0de, 120, 1'b1, endc);
    chk("tie_end_cycle", 64'(endc), 64'd100);
    @(posedge clk); #1;

    // reset mid-load: second accepted word's write never lands
    start(9'd4, 24'd0);
    prog_valid = 1'b1; prog_data = 16'h5555;
    @(negedge clk);
    if (prog_ready) exp_wr.push_back('{addr: 8'd0, data: 16'h5555});
    @(posedge clk); #1;
    prog_data = 16'h6666; reset = 1'b1; ign_fall = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; prog_valid = 1'b0;
    chk("abort_we",    {63'd0, imem_we}, 64'd0);
    chk("abort_ready", {63'd0, prog_ready}, 64'd0);
    chk("abort_srst",  {63'd0, cpu_soft_reset}, 64'd1);
    chk("abort_busy",  {63'd0, busy}, 64'd0);
    chk("abort_done",  {63'd0, done}, 64'd0);
    @(negedge clk);
    @(posedge clk); #1;
    ign_fall = 1'b0;
    start(9'd4, 24'd0);
    load(wb, 1'b0, rdy, blo);
    release_chk();
    exp_res.push_back('{d: 1'b1, t: 1'b0, r: 16'h00aa, c: 24'd3});
    run_phase(0, 3, 16'h00aa, 40, 1'b0, endc);
    chk("reload_end_cycle", 64'(endc), 64'd3);
    repeat (2) @(posedge clk);
    @(negedge clk);

    chk("wr_queue_empty",  64'(exp_wr.size()), 64'd0);
    chk("res_queue_empty", 64'(exp_res.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mini16sc_boot_ctrl.md
Name: mini16sc_boot_ctrl

Overview:
Sequencer that boots and supervises one mini16sc core. It holds the core in soft reset and streams a program from a host valid/ready source into instruction RAM. It then releases the core and counts run cycles. It halts the core again when the core stores to a mailbox address (done) or when a cycle budget expires (timeout).

Parameters:
WIDTH_I, 16, instruction word width
DEPTH_I, 8, instruction RAM address width
WIDTH_D, 16, data word width
DEPTH_D, 8, data RAM address width
DONE_ADDR, 8'hff, data address whose store signals program completion
CNT_BITS, 24, width of cycle counter and timeout budget

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cmd_start  in  1  single-cycle start request
cmd_len  in  DEPTH_I+1  program word count; 0 = skip load, run existing image
cmd_timeout  in  CNT_BITS  run-cycle budget; 0 = unlimited
prog_valid  in  1  program word available
prog_data  in  WIDTH_I  program word
prog_ready  out  1  controller accepts a word
imem_w_addr  out  DEPTH_I  instruction RAM write address
imem_w_data  out  WIDTH_I  instruction RAM write data
imem_we  out  1  instruction RAM write enable
cpu_soft_reset  out  1  drives core soft_reset
snoop_d_we  in  1  core mem_d_we
snoop_d_w_addr  in  DEPTH_D  core mem_d_w_addr
snoop_d_w_data  in  WIDTH_D  core mem_d_w_data
busy  out  1  high in LOAD/RELEASE/RUN
done  out  1  run ended by mailbox store (sticky)
timed_out  out  1  run ended by budget expiry (sticky)
result  out  WIDTH_D  data of mailbox store
cycles  out  CNT_BITS  RUN cycles of last/current run

Behaviour:
- States: IDLE, LOAD, RELEASE, RUN, HALT. Everything is decoded from registered state.
- Reset values: state IDLE; prog_ready 0; imem_we 0; imem_w_addr 0; imem_w_data 0; cpu_soft_reset 1; busy 0; done 0; timed_out 0; result 0; cycles 0. Reset in any state aborts the operation. A pending write does not occur: imem_we is 0 in the next cycle.
- cpu_soft_reset = (state != RUN). prog_ready = (state == LOAD). busy = state in {LOAD, RELEASE, RUN}.
- IDLE/HALT: cmd_start latches len (clipped to 2^DEPTH_I) and timeout. It clears done, timed_out, result and cycles, and resets the word counter to 0. Next state is LOAD if len != 0, else RELEASE. cmd_start in LOAD/RELEASE/RUN is ignored.
- LOAD: each cycle with prog_valid & prog_ready accepts a word. The next cycle has imem_we=1, imem_w_addr=counter, imem_w_data=prog_data. The counter then increments, wrapping at 2^DEPTH_I. Cycles without valid produce imem_we=0. The accept of word len-1 moves to RELEASE, so prog_ready drops the following cycle.
- RELEASE: lasts exactly 1 cycle. The last imem write completes here while the core is still in reset. Next state is RUN.
- RUN: cycles <= cycles+1 every cycle, saturating at all-ones.
  - Done: snoop_d_we=1 and snoop_d_w_addr==DONE_ADDR. Sets result <= snoop_d_w_data and done <= 1, then HALT.
  - Timeout: cmd_timeout != 0 and cycles+1 == cmd_timeout. Sets timed_out <= 1, then HALT.
  - Done and timeout in the same cycle: done wins, timed_out stays 0.
  - Stores to other addresses are ignored.
- HALT: the core is held in reset. done, timed_out, result and cycles hold until the next cmd_start.
- Throughput: 1 word/cycle. Load of N words with continuous valid takes N LOAD cycles plus 1 RELEASE cycle.

Test Plan:
- Reset, then cmd_start with len=4 and words 0x1111/0x2222/0x3333/0x4444 with continuous valid:
  - prog_ready is high 4 cycles.
  - imem writes go to addr 0..3 with those data.
  - cpu_soft_reset falls 2 cycles after the 4th accept.
  - busy stays 1 throughout.
- Same load with valid low every other cycle: identical imem contents, imem_we only after accepted words, 8 LOAD cycles.
- RUN with timeout=0 and a store to 0x10 on RUN cycle 3, then a store of 0x1234 to 0xff on RUN cycle 10:
  - done=1, result=0x1234, cycles=10, timed_out=0.
  - cpu_soft_reset=1 and busy=0 the next cycle.
- timeout=100 with no mailbox store: timed_out=1 and cycles=100 after exactly 100 RUN cycles. Repeat with the mailbox store on RUN cycle 100: done=1, timed_out=0.
- cmd_len=0 start: LOAD is skipped, RELEASE lasts 1 cycle, then RUN. cmd_start during RUN has no effect on state or counters.
- Reset asserted after 2 of 4 words are accepted: next cycle state is IDLE, imem_we=0, prog_ready=0, cpu_soft_reset=1. A new start reloads from addr 0.
